// File: rtl/softmax_maxnorm_buf.sv
// rtl/softmax_maxnorm_buf.sv - row buffer with running max; streams X - max per tile
// Loads one row of tiles, then drains it as saturated (X - max) with ready/valid.
module softmax_maxnorm_buf #(
  parameter int WIDTH        = 32,
  parameter int FRAC_WIDTH   = 16,
  parameter int MAX_ELEMENTS = 64,
  parameter int TILE_SIZE    = 4
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 en,
  input  logic                                 start,
  input  logic [$clog2(MAX_ELEMENTS+1)-1:0]    row_len,
  input  logic [TILE_SIZE*WIDTH-1:0]           X_tile_in,
  input  logic                                 tile_in_valid,
  output logic                                 tile_in_ready,
  output logic [TILE_SIZE*WIDTH-1:0]           Y_tile_out,
  output logic                                 tile_out_valid,
  input  logic                                 tile_out_ready,
  output logic [WIDTH-1:0]                     max_out,
  output logic                                 max_valid,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 err
);

  localparam int NT_MAX = MAX_ELEMENTS / TILE_SIZE;
  localparam int IDX_W  = (NT_MAX > 1) ? $clog2(NT_MAX) : 1;
  localparam int CNT_W  = IDX_W + 1;
  localparam int LEN_W  = $clog2(MAX_ELEMENTS + 1);
  localparam int LANE_W = $clog2(TILE_SIZE + 1);
  localparam int TW     = TILE_SIZE * WIDTH;
  localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(MAX_ELEMENTS);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  if (FRAC_WIDTH >= WIDTH || (MAX_ELEMENTS % TILE_SIZE) != 0) begin : g_bad_params
    $error("softmax_maxnorm_buf: illegal parameterisation");
  end

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN} state_e;

  state_e                    state_q, state_d;
  logic [IDX_W-1:0]          ntm1_q, ntm1_d;
  logic [LANE_W-1:0]         vl_q, vl_d;
  logic [IDX_W-1:0]          in_cnt_q, in_cnt_d;
  logic [CNT_W-1:0]          rd_q, rd_d;
  logic signed [WIDTH-1:0]   max_q, max_d;
  logic                      max_valid_q, max_valid_d;
  logic [TW-1:0]             y_q, y_d;
  logic                      out_valid_q, out_valid_d;
  logic                      done_q, done_d;
  logic                      err_q, err_d;

  logic [TW-1:0]             mem [NT_MAX];

  logic                      in_acc, last_in, row_len_ok;
  logic [LANE_W-1:0]         n_valid;
  logic signed [WIDTH-1:0]   tile_max, lane_x;
  logic [TW-1:0]             rd_tile, y_calc;
  logic [WIDTH-1:0]          rx;
  logic [WIDTH:0]            diff;

  assign tile_in_ready = en && (state_q == S_LOAD);
  assign in_acc        = tile_in_valid && tile_in_ready;
  assign last_in       = (in_cnt_q == ntm1_q);
  assign row_len_ok    = (row_len != '0) && (row_len <= MAX_LEN);
  assign rd_tile       = mem[rd_q[IDX_W-1:0]];

  assign Y_tile_out     = y_q;
  assign tile_out_valid = out_valid_q;
  assign max_out        = max_q;
  assign max_valid      = max_valid_q;
  assign busy           = (state_q != S_IDLE);
  assign done           = done_q;
  assign err            = err_q;

  always_ff @(posedge clk) begin
    if (in_acc) mem[in_cnt_q] <= X_tile_in;
  end

  // Running max over valid lanes; the first beat seeds it from lane 0, ties keep the old value.
  always_comb begin
    lane_x   = '0;
    n_valid  = last_in ? vl_q : LANE_W'(TILE_SIZE);
    tile_max = (in_cnt_q == '0) ? X_tile_in[TW-1 -: WIDTH] : max_q;
    for (int i = 0; i < TILE_SIZE; i++) begin
      lane_x = X_tile_in[(TILE_SIZE-1-i)*WIDTH +: WIDTH];
      if ((LANE_W'(i) < n_valid) && (lane_x > tile_max)) tile_max = lane_x;
    end
  end

  always_comb begin
    y_calc = '0;
    rx     = '0;
    diff   = '0;
    for (int i = 0; i < TILE_SIZE; i++) begin
      rx   = rd_tile[(TILE_SIZE-1-i)*WIDTH +: WIDTH];
      diff = {rx[WIDTH-1], rx} - {max_q[WIDTH-1], max_q};
      if ((rd_q[IDX_W-1:0] == ntm1_q) && (LANE_W'(i) >= vl_q))
        y_calc[(TILE_SIZE-1-i)*WIDTH +: WIDTH] = MOST_NEG;
      else if (diff[WIDTH] && !diff[WIDTH-1])
        y_calc[(TILE_SIZE-1-i)*WIDTH +: WIDTH] = MOST_NEG;
      else
        y_calc[(TILE_SIZE-1-i)*WIDTH +: WIDTH] = diff[WIDTH-1:0];
    end
  end

  always_comb begin
    state_d     = state_q;
    ntm1_d      = ntm1_q;
    vl_d        = vl_q;
    in_cnt_d    = in_cnt_q;
    rd_d        = rd_q;
    max_d       = max_q;
    max_valid_d = max_valid_q;
    y_d         = y_q;
    out_valid_d = out_valid_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (row_len_ok) begin
            ntm1_d   = IDX_W'((int'(row_len) - 1) / TILE_SIZE);
            vl_d     = LANE_W'(int'(row_len) - ((int'(row_len) - 1) / TILE_SIZE) * TILE_SIZE);
            in_cnt_d = '0;
            rd_d     = '0;
            state_d  = S_LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        if (in_acc) begin
          max_d    = tile_max;
          in_cnt_d = in_cnt_q + IDX_W'(1);
          if (last_in) begin
            max_valid_d = 1'b1;
            state_d     = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        // Output register refills whenever it is empty or being consumed this cycle.
        if ((rd_q <= {1'b0, ntm1_q}) && (!out_valid_q || tile_out_ready)) begin
          y_d         = y_calc;
          out_valid_d = 1'b1;
          rd_d        = rd_q + CNT_W'(1);
        end else if (out_valid_q && tile_out_ready) begin
          out_valid_d = 1'b0;
          max_valid_d = 1'b0;
          done_d      = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ntm1_q      <= '0;
      vl_q        <= '0;
      in_cnt_q    <= '0;
      rd_q        <= '0;
      max_q       <= '0;
      max_valid_q <= 1'b0;
      y_q         <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else if (en) begin
      state_q     <= state_d;
      ntm1_q      <= ntm1_d;
      vl_q        <= vl_d;
      in_cnt_q    <= in_cnt_d;
      rd_q        <= rd_d;
      max_q       <= max_d;
      max_valid_q <= max_valid_d;
      y_q         <= y_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

endmodule
